// File: rtl/imsic_pkg.sv
// imsic_pkg: constants, CSR offsets and request type shared by the IMSIC blocks.
package imsic_pkg;
    localparam int IMSIC_NR_INTP_FILES   = 7;
    localparam int IMSIC_XLEN            = 64;
    localparam int IMSIC_NR_SRC_WIDTH    = 8;
    localparam int IMSIC_NR_REG          = 1;
    localparam int IMSIC_INTP_FILE_WIDTH = 3;
    localparam int IMSIC_EIP_BIT_W       = $clog2(IMSIC_XLEN);
    localparam int IMSIC_NR_EIP          = IMSIC_NR_INTP_FILES * IMSIC_NR_REG;

    localparam logic [11:0] EIDELIVERY_OFF  = 12'h070;
    localparam logic [11:0] EITHRESHOLD_OFF = 12'h072;
    localparam logic [11:0] EIP0_OFF        = 12'h080;
    localparam logic [11:0] EIE0_OFF        = 12'h0C0;

    typedef struct packed {
        logic [IMSIC_INTP_FILE_WIDTH-1:0] file;
        logic [IMSIC_NR_SRC_WIDTH-1:0]    id;
    } msi_req_t;
endpackage

// File: rtl/imsic_msi_fifo.sv
// imsic_msi_fifo: generic synchronous FIFO with occupancy count and full/empty flags.
module imsic_msi_fifo #(
    parameter int DEPTH = 4,
    parameter type T = logic
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wr_data,
    output T                         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Entries need no reset: they are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    assign rd_data = mem[rd_ptr];
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
endmodule

// File: rtl/imsic_msi_pend.sv
// imsic_msi_pend: buffers MSI setipnum writes and merges them with software
// eip writes into the per-file pending-bit registers.
module imsic_msi_pend
    import imsic_pkg::*;
#(
    parameter int NR_INTP_FILES   = IMSIC_NR_INTP_FILES,
    parameter int XLEN            = IMSIC_XLEN,
    parameter int NR_SRC_WIDTH    = IMSIC_NR_SRC_WIDTH,
    parameter int NR_REG          = IMSIC_NR_REG,
    parameter int INTP_FILE_WIDTH = IMSIC_INTP_FILE_WIDTH,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         msi_vld,
    output logic                                         msi_rdy,
    input  logic [INTP_FILE_WIDTH-1:0]                   msi_intp_file_sel,
    input  logic [NR_SRC_WIDTH-1:0]                      msi_setipnum,
    input  logic [NR_INTP_FILES*NR_REG-1:0][XLEN-1:0]    eip_sw,
    input  logic [NR_INTP_FILES*NR_REG-1:0]              eip_sw_wr,
    output logic [NR_INTP_FILES*NR_REG-1:0][XLEN-1:0]    eip_final,
    output logic                                         msi_drop
);
    localparam int NR_EIP = NR_INTP_FILES * NR_REG;
    localparam int BIT_W  = $clog2(XLEN);

    msi_req_t                    push_req, head;
    logic                        full, empty, head_ok, stall, pop;
    logic [$clog2(FIFO_DEPTH):0] unused_count;
    logic [NR_EIP-1:0]           hit, set;
    logic [BIT_W-1:0]            bit_idx;
    logic [NR_EIP-1:0][XLEN-1:0] eip;

    assign push_req = '{file: msi_intp_file_sel, id: msi_setipnum};
    assign msi_rdy  = !full;

    imsic_msi_fifo #(.DEPTH(FIFO_DEPTH), .T(msi_req_t)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (msi_vld && msi_rdy),
        .pop     (pop),
        .wr_data (push_req),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (unused_count)
    );

    always_comb begin
        bit_idx = head.id[BIT_W-1:0];
        head_ok = !empty && int'(head.file) < NR_INTP_FILES
                  && int'(head.id) < NR_REG * XLEN && head.id != '0;
        for (int k = 0; k < NR_EIP; k++)
            hit[k] = head_ok && (int'(head.file) * NR_REG + (int'(head.id) >> BIT_W) == k);
    end

    // A software write to the target register wins and holds the head back a cycle.
    assign stall    = |(hit & eip_sw_wr);
    assign pop      = !empty && !stall;
    assign set      = stall ? '0 : hit;
    assign msi_drop = !empty && !head_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eip <= '0;
        end else begin
            for (int k = 0; k < NR_EIP; k++)
                if (eip_sw_wr[k]) eip[k] <= eip_sw[k] & ~(XLEN'(k % NR_REG == 0));
                else if (set[k]) eip[k][bit_idx] <= 1'b1;
        end
    end

    assign eip_final = eip;
endmodule

// File: doc/imsic_msi_pend.md
# imsic_msi_pend

Pending-bit store for the IMSIC interrupt files. It accepts incoming MSI setipnum writes (file select plus interrupt identity) through a valid/ready channel and buffers them in a small FIFO. It drains the FIFO into per-file eip registers and merges in software eip writes from the CSR register block. The resulting eip_final array drives that CSR block for xtopei selection and eip reads.

## Interface
- NR_INTP_FILES, 7, number of interrupt files (m, s, 5 vs)
- XLEN, 64, bits per eip register
- NR_SRC_WIDTH, 8, width of interrupt identity
- NR_REG, 1, eip registers per file
- INTP_FILE_WIDTH, 3, width of file select
- FIFO_DEPTH, 4, MSI buffer entries (power of 2, ≥2)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- msi_vld  in  1  MSI setipnum request valid
- msi_rdy  out  1  request accepted when msi_vld & msi_rdy
- msi_intp_file_sel  in  INTP_FILE_WIDTH  target interrupt file
- msi_setipnum  in  NR_SRC_WIDTH  interrupt identity to set pending
- eip_sw  in  XLEN × (NR_INTP_FILES*NR_REG)  software-written eip values
- eip_sw_wr  in  NR_INTP_FILES*NR_REG  one-cycle write strobe per eip register
- eip_final  out  XLEN × (NR_INTP_FILES*NR_REG)  current pending bits
- msi_drop  out  1  one-cycle pulse: popped request discarded as invalid

## Operation
- Push: on msi_vld & msi_rdy, store {file, id} at the write pointer. msi_rdy = !full, from registered state only. No combinational path from msi_vld or from pop.
- Pop: head is popped every cycle the FIFO is non-empty, except when stalled.
- Decode of the head entry:
  - reg index r = file*NR_REG + id/XLEN
  - bit b = id % XLEN
- Invalid head entries are popped without modifying eip, and msi_drop pulses in the same cycle. An entry is invalid when:
  - file ≥ NR_INTP_FILES, or
  - id ≥ NR_REG*XLEN, or
  - id == 0.
- Stall: if eip_sw_wr[r] is high for the head's valid r, the head is not popped that cycle. The software write is applied, and the MSI bit is set on a later cycle. Ordering is therefore always software write first, then MSI set.
- eip update per register k, each clock:
  - if eip_sw_wr[k]: eip[k] <= eip_sw[k] with bit 0 of register index 0 of each file forced to 0
  - else if a valid pop targets k: eip[k][b] <= 1
  - otherwise hold
- Setting a bit that is already pending has no visible effect.
- eip_final is the eip register array directly; there is no extra pipeline stage.
- Occupancy counter, width $clog2(FIFO_DEPTH)+1:
  - full when count == FIFO_DEPTH, empty when 0
  - pointers wrap modulo FIFO_DEPTH
  - simultaneous push and pop leaves the count unchanged
- Reset (async, any time, including mid-drain):
  - FIFO pointers and count = 0, entries are don't-care
  - all eip = 0
  - msi_rdy = 1 after reset release, msi_drop = 0
  - in-flight requests are lost

## Timing
- Request accepted at edge E, FIFO empty, no stall: the bit is visible on eip_final after edge E+1 (2-cycle latency from presentation).
- Each stall cycle adds one cycle of latency.
- Throughput is 1 request per cycle when there are no stalls. msi_rdy falls only under sustained stalls.
- At full, msi_rdy is low for the entire cycle, even if a pop occurs in that cycle. It rises after the edge that decrements the count.
- msi_drop is asserted combinationally in the pop cycle; it is not registered.
- An eip_sw_wr pulse updates eip_final after the same edge.

## Structure
- Package imsic_pkg holds:
  - CSR offset constants shared with the CSR block
  - typedef msi_req_t {file, id}
  - localparam helpers for reg index/bit width
- Sub-module imsic_msi_fifo: generic synchronous FIFO (DEPTH, payload type) with full/empty/count outputs.
- This module instantiates one FIFO and contains the decode, stall and eip merge logic.

## Test plan
- Reset, then a single MSI with file=1, id=5: eip_final[1][5]=1 exactly 2 cycles after msi_vld was presented; msi_drop never pulses.
- MSIs with id=0, file=7, and id=64 (NR_REG=1, XLEN=64): three msi_drop pulses, eip_final unchanged.
- eip_sw_wr[2] held high for 6 cycles with eip_sw[2]=0, while MSIs to file 2 stream every cycle: msi_rdy falls after 4 accepts. After the strobe drops, the 4 buffered bits appear one per cycle.
- Same cycle as a pending head for file 0 id 3: eip_sw_wr[0] with eip_sw[0]=64'h1 → eip_final[0] becomes 64'h0 first (bit 0 forced clear), then 64'h8 one cycle later.
- Back-to-back 8 MSIs with no stalls: all accepted with msi_rdy constant 1, and the count never exceeds 1.
- rstn asserted with 3 entries queued: eip_final = 0 and msi_rdy = 1 after release. Subsequent file=0, id=1 works with 2-cycle latency.
